siso_shift_ctrl: RTL

- Sequencing controller for a serial-in serial-out shift chain built from reset-able D flip-flop stages.
- Accepts a parallel word on a valid/ready handshake and shifts it LSB-first into a DEPTH-stage SISO chain.
- Captures the bits as they emerge from the chain, reassembles the word and presents it on an output valid/ready handshake.
- Serves as the word-level front end for serial links and delay lines built from the flop chain.

---
 rtl/siso_shift_pkg.sv | 16 +
 rtl/siso_chain.sv | 33 +++
 rtl/siso_shift_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/siso_shift_pkg.sv
// Shared definitions for the SISO shift controller: state encoding and
// counter sizing.
package siso_shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // The counter must reach WIDTH+DEPTH (parity word, last capture) without wrapping.
   function automatic int cnt_width(input int width, input int depth);
      return $clog2(width + 1 + depth);
   endfunction

endpackage

// File: rtl/siso_chain.sv
// DEPTH-stage serial-in serial-out chain of resettable D flip-flops.
// Stages only advance while en is high; sout is the last stage.
module siso_chain #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sin,
   output logic sout
);

   logic [DEPTH-1:0] stage_q;

   generate
      if (DEPTH == 1) begin : g_single
         // A single stage simply samples the serial input.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) stage_q <= '0;
            else if (en) stage_q <= sin;
         end
      end else begin : g_multi
         // Each enabled edge moves every bit one stage toward sout.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) stage_q <= '0;
            else if (en) stage_q <= {stage_q[DEPTH-2:0], sin};
         end
      end
   endgenerate

   assign sout = stage_q[DEPTH-1];

endmodule

// File: rtl/siso_shift_ctrl.sv
// Word-level front end for a SISO flop chain: accepts a parallel word,
// shifts it LSB-first through the chain, reassembles the bits that emerge
// and offers the word on an output valid/ready handshake.
// Optional feature macro: SISO_SHIFT_CTRL_PARITY_EN appends an even-parity
// bit to each word and flags a mismatch on reception.
module siso_shift_ctrl
   import siso_shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             sin_mon,
   output logic             parity_err
);

`ifdef SISO_SHIFT_CTRL_PARITY_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif

   localparam int CW = cnt_width(WIDTH, DEPTH);
   localparam logic [CW-1:0] N_C       = CW'(N);
   localparam logic [CW-1:0] CAP_FIRST = CW'(DEPTH);
   localparam logic [CW-1:0] CAP_LAST  = CW'(DEPTH + WIDTH - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(N + DEPTH - 1);

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [N-1:0]     tx_q;
   logic [WIDTH-1:0] rx_q;
   logic             out_valid_q;
   logic             sin_d;
   logic             sout;
   logic             chain_en;

   // Feed the chain from the tx buffer LSB while word bits remain, zeros after.
   always_comb begin
      sin_d = 1'b0;
      if (state_q == SHIFT && cnt_q < N_C) sin_d = tx_q[0];
   end

   assign chain_en = (state_q == SHIFT);

   siso_chain #(
      .DEPTH(DEPTH)
   ) u_chain (
      .clk (clk),
      .rst (rst),
      .en  (chain_en),
      .sin (sin_d),
      .sout(sout)
   );

`ifdef SISO_SHIFT_CTRL_PARITY_EN
   localparam logic [CW-1:0] PAR_POS = CW'(DEPTH + WIDTH);

   logic rx_par_q;

   // Hold the received parity bit apart from the data collector.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rx_par_q <= 1'b0;
      else if (state_q == IDLE && in_valid) rx_par_q <= 1'b0;
      else if (state_q == SHIFT && cnt_q == PAR_POS) rx_par_q <= sout;
   end

   assign parity_err = out_valid_q & (^{rx_par_q, rx_q});
`else
   assign parity_err = 1'b0;
`endif

   // Sequencer: load, shift/collect, then hold the result until taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         out_valid_q <= 1'b0;
      end else if (clear) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
`ifdef SISO_SHIFT_CTRL_PARITY_EN
                  tx_q <= {^in_data, in_data};
`else
                  tx_q <= in_data;
`endif
                  cnt_q   <= '0;
                  rx_q    <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               tx_q <= tx_q >> 1;
               if (cnt_q >= CAP_FIRST && cnt_q <= CAP_LAST)
                  rx_q <= {sout, rx_q[WIDTH-1:1]};
               if (cnt_q == CNT_LAST) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = rx_q;
   assign sin_mon   = sin_d;

endmodule
